// File: rtl/priority_scan_encoder_pkg.sv
// Shared types and helpers for the priority scan encoder.
// Build option: PSE_LSB_FIRST_EN selects LSB-first scan order (see prio_enc_comb).
package pse_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // True when at most one bit is set; callers zero-extend narrower vectors.
    function automatic logic onehot_le1(input logic [63:0] vec);
        return (vec & (vec - 64'd1)) == 64'd0;
    endfunction

endpackage

// File: rtl/priority_scan_encoder_if.sv
// Handshake bundle for priority_scan_encoder: request vector in, index stream out.
// slave is the encoder's view, master is the requester/consumer view.
interface priority_scan_encoder_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         idle;

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, idle
    );

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, idle
    );

endinterface

// File: rtl/priority_scan_encoder_prio_enc_comb.sv
// Combinational N-to-W priority encoder with zero flag; generalised 8x3 encoder.
// Build option: PSE_LSB_FIRST_EN makes the lowest set bit win instead of the highest.
module prio_enc_comb #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         zero
);

    // Later loop iterations override earlier ones, so loop direction sets priority.
    always_comb begin
        idx = '0;
`ifdef PSE_LSB_FIRST_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
`else
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = W'(i);
        end
`endif
        zero = ~|vec;
    end

endmodule

// File: rtl/priority_scan_encoder.sv
// Registered priority scan encoder: accepts a request vector, then emits each set index in turn.
// Build option: PSE_LSB_FIRST_EN (scan order, handled in prio_enc_comb).
module priority_scan_encoder
    import pse_pkg::*;
#(
    parameter int N = 8
) (
    input logic                    clk,
    input logic                    rst,
    priority_scan_encoder_if.slave bus
);

    localparam int W = $clog2(N);

    state_e       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] enc_idx;
    logic         enc_zero;
    logic         scan;
    logic         last;

    prio_enc_comb #(
        .N(N)
    ) u_enc (
        .vec (pending_q),
        .idx (enc_idx),
        .zero(enc_zero)
    );

    assign scan = (state_q == SCAN) && !enc_zero;
    assign last = scan && onehot_le1(64'(pending_q));

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = scan;
    assign bus.out_idx   = scan ? enc_idx : '0;
    assign bus.out_last  = last;
    assign bus.idle      = (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            IDLE: begin
                // A zero vector is accepted but produces no beats.
                if (bus.in_valid && bus.in_ready && |bus.in_vec) begin
                    pending_d = bus.in_vec;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    pending_d[enc_idx] = 1'b0;
                    if (last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: doc/priority_scan_encoder.md
Name: priority_scan_encoder

Overview:
Parametrised, registered successor of the 8-to-3 priority encoder. It accepts an N-bit request vector with a valid/ready handshake. It then emits the index of every set bit, one per cycle, in priority order (MSB first by default), clearing each bit as it is consumed. It is used wherever multiple pending requests must be serviced sequentially, not just reported as the single highest one.

Parameters:
N, 8, request vector width; legal range 2..64.
W, $clog2(N), index width; derived localparam, not overridable.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_vec is presented.
in_ready  output  1  block can accept a vector.
in_vec  input  N  request vector.
out_valid  output  1  out_idx holds a valid index.
out_ready  input  1  consumer accepts out_idx.
out_idx  output  W  index of the current highest-priority pending bit.
out_last  output  1  current index is the last pending bit of this vector.
idle  output  1  no requests pending; analogue of the legacy idle flag.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - state=IDLE, pending=0.
  - out_valid=0, out_idx=0, out_last=0.
  - idle=1.
  - in_ready=0 while rst is high, 1 from the first cycle after release.
- State IDLE:
  - in_ready=1, idle=1, out_valid=0.
  - Accept occurs on a clock edge with in_valid && in_ready.
  - Nonzero in_vec: pending<=in_vec, go to SCAN.
  - Zero in_vec: accepted and dropped; stay in IDLE; no output beat.
- State SCAN:
  - in_ready=0, idle=0, out_valid=1.
  - out_idx = priority encode of the registered pending vector.
  - out_last = 1 when exactly one bit of pending is set.
- Beat: out_valid && out_ready at an edge clears pending[out_idx].
  - If out_last, go to IDLE.
  - Otherwise stay in SCAN; the next index appears in the following cycle.
- Latency:
  - Accept at edge k gives the first out_valid in the cycle after edge k.
  - One index per cycle while out_ready=1.
  - After the last beat, IDLE for one cycle; a new vector can be accepted at that edge.
  - Throughput for a vector with P set bits: P+1 cycles.
- Backpressure: while out_valid && !out_ready, out_idx, out_last and pending hold stable.
- out_idx=0 and out_last=0 whenever out_valid=0.
- Reset mid-SCAN: the next cycle shows IDLE outputs and pending=0; remaining indices are discarded.
- Simultaneous rst and handshake: rst wins, and neither the input nor the output handshake takes effect.
- Indices always fit in W bits; no arithmetic overflow.

Optional Feature:
- Macro PSE_LSB_FIRST_EN.
- Defined: priority is inverted, so the lowest set index is emitted first and out_last marks the highest set bit.
- Undefined: MSB-first, matching the legacy encoder.
- Handshake and timing are identical in both builds.

Decomposition:
- Package pse_pkg:
  - state enum (IDLE, SCAN).
  - Function onehot_le1(vec) for out_last.
- Sub-module prio_enc_comb:
  - Combinational N-to-W priority encoder with a zero flag.
  - Honours PSE_LSB_FIRST_EN.
  - Directly reusable as the generalised form of the 8x3 encoder.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> during reset idle=1, out_valid=0, out_idx=0, in_ready=0; in_ready=1 in the first cycle after release.
- Normal scan: in_vec=8'b00100101, out_ready=1 -> out_idx 5, 2, 0 on consecutive cycles; out_last=1 only on 0; in_ready=0 throughout; idle=1 the cycle after.
- Backpressure: in_vec=8'b10000001, out_ready=0 for 3 cycles then 1 -> out_idx=7 held 4 cycles, then 0 with out_last=1; no index lost or duplicated.
- Zero vector: in_vec=8'h00 accepted -> out_valid never asserts, idle stays 1, in_ready stays 1.
- Reset mid-scan: in_vec=8'b00011110, rst asserted after the beat for idx 4 -> next cycle out_valid=0, idle=1; a following in_vec=8'b00000010 yields only idx 1.
- Mode/width:
  - With PSE_LSB_FIRST_EN, in_vec=8'b00100101 -> 0, 2, 5.
  - With N=16 (default build), in_vec=16'h8001 -> 15, 0 with out_last on 0.
